// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states,
// default timeout and the misalignment predicate.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Size 2'b11 is handled as a word access everywhere.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and replicated write data for stores,
// lane extraction plus sign/zero extension for loads.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);

  logic [1:0]        eff_off;
  logic [DATA_W-1:0] shifted;

  // Low address bits that a half/word access cannot use are ignored here.
  always_comb begin
    eff_off = 2'b00;
    be      = 4'b1111;
    case (size)
      SZ_BYTE: begin
        eff_off = byte_off;
        be      = 4'b0001 << byte_off;
      end
      SZ_HALF: begin
        eff_off = {byte_off[1], 1'b0};
        be      = 4'b0011 << {byte_off[1], 1'b0};
      end
      default: begin
        eff_off = 2'b00;
        be      = 4'b1111;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata[gi*8 +: 8] = (size == SZ_BYTE) ? store_data[7:0] :
                                (size == SZ_HALF) ? store_data[(gi%2)*8 +: 8] :
                                                    store_data[gi*8 +: 8];
    end
  endgenerate

  assign shifted = rdata >> {eff_off, 3'b000};

  always_comb begin
    load_data = shifted;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access unit: one load/store per start over a req/ready handshake
// with timeout. Define MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_e        state_reg, state_next;
  logic              is_store_reg, is_store_next;
  logic [1:0]        size_reg, size_next;
  logic              sign_ext_reg, sign_ext_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] store_data_reg, store_data_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [DATA_W-1:0] load_data_reg, load_data_next;
  logic              err_reg, err_next;

  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_load;
  logic              trap;

`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(size, addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .size      (size_reg),
    .sign_ext  (sign_ext_reg),
    .byte_off  (addr_reg[1:0]),
    .store_data(store_data_reg),
    .rdata     (mem_rdata),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .load_data (lane_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      is_store_reg   <= 1'b0;
      size_reg       <= 2'b00;
      sign_ext_reg   <= 1'b0;
      addr_reg       <= '0;
      store_data_reg <= '0;
      cnt_reg        <= '0;
      load_data_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      is_store_reg   <= is_store_next;
      size_reg       <= size_next;
      sign_ext_reg   <= sign_ext_next;
      addr_reg       <= addr_next;
      store_data_reg <= store_data_next;
      cnt_reg        <= cnt_next;
      load_data_reg  <= load_data_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    is_store_next   = is_store_reg;
    size_next       = size_reg;
    sign_ext_next   = sign_ext_reg;
    addr_next       = addr_reg;
    store_data_next = store_data_reg;
    cnt_next        = cnt_reg;
    load_data_next  = load_data_reg;
    err_next        = err_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          is_store_next   = is_store;
          size_next       = size;
          sign_ext_next   = sign_ext;
          addr_next       = addr;
          store_data_next = store_data;
          cnt_next        = '0;
          load_data_next  = '0;
          err_next        = trap;
          state_next      = trap ? DONE : REQ;
        end
      end
      REQ: begin
        cnt_next = cnt_reg + 8'd1;
        if (mem_ready) begin
          if (!is_store_reg) load_data_next = lane_load;
          state_next = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next       = 1'b1;
          load_data_next = '0;
          state_next     = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side outputs are forced to zero outside REQ so nothing stale leaks.
  assign busy      = (state_reg == REQ);
  assign done      = (state_reg == DONE);
  assign mem_req   = busy;
  assign mem_we    = mem_req & is_store_reg;
  assign mem_addr  = mem_req ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? lane_be : 4'b0000;
  assign mem_wdata = mem_req ? lane_wdata : '0;
  assign load_data = load_data_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a scoreboard of expected
// completions and hand-written reset/hold sequences.
module tb_load_store_unit;

  localparam int TO = 4;

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] maddr;
    logic [31:0] load;
    logic        err;
    int          lat;
    int          reqs;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;
  vec_t tbl[12];
  vec_t sb[$];

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .store_data(store_data),
    .busy      (busy),
    .done      (done),
    .load_data (load_data),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                              input int waits, input logic [3:0] be, input logic [31:0] wd,
                              input logic [31:0] ma, input logic [31:0] ld, input logic e,
                              input int lat, input int reqs);
    vec_t v;
    v.st = st; v.sz = sz; v.sx = sx; v.addr = a; v.sdata = sd; v.rdata = rd;
    v.waits = waits; v.be = be; v.wdata = wd; v.maddr = ma; v.load = ld;
    v.err = e; v.lat = lat; v.reqs = reqs;
    return v;
  endfunction

  // waits >= 255 means the memory never answers.
  task automatic run_vec(input vec_t v);
    int cyc, reqs;
    logic seen, unstable, fin;
    logic [31:0] a0, w0;
    logic [3:0] b0;
    logic we0;
    vec_t e;
    @(negedge clk);
    is_store = v.st; size = v.sz; sign_ext = v.sx; addr = v.addr; store_data = v.sdata;
    start = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    mem_rdata = v.rdata;
    cyc = 1; reqs = 0; seen = 1'b0; unstable = 1'b0; fin = 1'b0;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
    while (!fin && cyc < 300) begin
      if (mem_req) begin
        if (!seen) begin
          a0 = mem_addr; b0 = mem_be; w0 = mem_wdata; we0 = mem_we; seen = 1'b1;
        end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {a0, b0, w0, we0}) begin
          unstable = 1'b1;
        end
        mem_ready = (v.waits < 255) && (reqs == v.waits);
        reqs++;
      end else begin
        mem_ready = 1'b0;
      end
      if (done) fin = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    mem_ready = 1'b0;
    n_txn++;
    if (!fin) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: txn %0d got no done after %0d cycles, expected one", n_txn, cyc);
      sb.delete();
      return;
    end
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: done with empty queue, expected a pending entry");
      return;
    end
    e = sb.pop_front();
    $display("txn %0d: st=%0b size=%0d addr=%h load_data=%h err=%0b latency=%0d reqs=%0d",
             n_txn, e.st, e.sz, e.addr, load_data, err, cyc, reqs);
    chk("load_data", load_data, e.load);
    chk("err", {31'b0, err}, {31'b0, e.err});
    chk("latency", cyc, e.lat);
    chk("req_cycles", reqs, e.reqs);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    if (e.reqs > 0) begin
      chk("mem_addr", a0, e.maddr);
      chk("mem_be", {28'b0, b0}, {28'b0, e.be});
      chk("mem_we", {31'b0, we0}, {31'b0, e.st});
      chk("req_stable", {31'b0, unstable}, 32'd0);
      if (e.st) chk("mem_wdata", w0, e.wdata);
    end
  endtask

  initial begin
    logic saw_done;
    reset = 1'b1; start = 1'b0; is_store = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; store_data = '0; mem_ready = 1'b0; mem_rdata = '0;

    //             st  sz     sx   addr          sdata         rdata         w    be       wdata         maddr         load          err lat reqs
    tbl[0]  = mk(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 0,   4'b1111, 32'h0,        32'h100, 32'hDEADBEEF, 1'b0, 2, 1);
    tbl[1]  = mk(1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        32'h80FF1234, 0,   4'b1000, 32'h0,        32'h100, 32'hFFFFFF80, 1'b0, 2, 1);
    tbl[2]  = mk(1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h80FF1234, 0,   4'b1000, 32'h0,        32'h100, 32'h00000080, 1'b0, 2, 1);
    tbl[3]  = mk(1'b1, 2'b01, 1'b0, 32'h22,  32'h0000ABCD, 32'h0,        3,   4'b1100, 32'hABCDABCD, 32'h20,  32'h0,        1'b0, 5, 4);
    tbl[4]  = mk(1'b0, 2'b10, 1'b0, 32'h40,  32'h0,        32'h55555555, 255, 4'b1111, 32'h0,        32'h40,  32'h0,        1'b1, TO+1, TO);
    tbl[5]  = mk(1'b0, 2'b10, 1'b0, 32'h44,  32'h0,        32'h12345678, 0,   4'b1111, 32'h0,        32'h44,  32'h12345678, 1'b0, 2, 1);
`ifdef MISALIGN_TRAP_EN
    tbl[6]  = mk(1'b0, 2'b10, 1'b0, 32'h101, 32'h0,        32'hCAFEF00D, 0,   4'b1111, 32'h0,        32'h100, 32'h0,        1'b1, 1, 0);
`else
    tbl[6]  = mk(1'b0, 2'b10, 1'b0, 32'h101, 32'h0,        32'hCAFEF00D, 0,   4'b1111, 32'h0,        32'h100, 32'hCAFEF00D, 1'b0, 2, 1);
`endif
    tbl[7]  = mk(1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'h80017FFF, 0,   4'b1100, 32'h0,        32'h10,  32'hFFFF8001, 1'b0, 2, 1);
    tbl[8]  = mk(1'b1, 2'b00, 1'b0, 32'h31,  32'h123456A5, 32'h0,        1,   4'b0010, 32'hA5A5A5A5, 32'h30,  32'h0,        1'b0, 3, 2);
    tbl[9]  = mk(1'b0, 2'b01, 1'b0, 32'h10,  32'h0,        32'h1234F00F, 2,   4'b0011, 32'h0,        32'h10,  32'h0000F00F, 1'b0, 4, 3);
    tbl[10] = mk(1'b0, 2'b11, 1'b1, 32'h8,   32'h0,        32'h0BADF00D, 0,   4'b1111, 32'h0,        32'h8,   32'h0BADF00D, 1'b0, 2, 1);
    tbl[11] = mk(1'b0, 2'b00, 1'b1, 32'h102, 32'h0,        32'h007F0000, 0,   4'b0100, 32'h0,        32'h100, 32'h0000007F, 1'b0, 2, 1);

    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset_load_data", load_data, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_be", {28'b0, mem_be}, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Reset asserted between edges while a request is outstanding.
    @(negedge clk);
    is_store = 1'b0; size = 2'b10; addr = 32'h200; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_mem_req", {31'b0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_mem_req", {31'b0, mem_req}, 32'd0);
    chk("async_reset_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("no_done_after_reset", {31'b0, saw_done}, 32'd0);
    run_vec(tbl[0]);

    // Result and flag must hold while idle.
    repeat (3) @(negedge clk);
    chk("load_data_held", load_data, 32'hDEADBEEF);
    chk("idle_mem_req", {31'b0, mem_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access unit of the RISC datapath, sitting between the execute stage and data memory.
- Issues one load or store per `start` using a req/ready handshake with wait states.
- Generates byte enables and replicated write data.
- Returns aligned, extended load data on `load_data`, which is the memory-side input of the writeback select.
- Asserts `busy` to stall the pipeline while an access is in flight.

Parameters:
- DATA_W, 32, data bus width (fixed 32; byte-lane logic assumes 4 lanes)
- ADDR_W, 32, byte address width
- TIMEOUT_CYC, 64, maximum cycles `mem_req` is held without `mem_ready` before abort (range 1..255)

Ports:
- Interface rule: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-high reset
- start  in  1  access request pulse; accepted only in IDLE
- is_store  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- sign_ext  in  1  loads: 1 = sign-extend, 0 = zero-extend
- addr  in  ADDR_W  byte address
- store_data  in  DATA_W  register data to store (low bits used for byte/half)
- busy  out  1  high from the cycle after `start` is accepted until `done`
- done  out  1  one-cycle completion pulse
- load_data  out  DATA_W  aligned load result; held until next accepted start
- err  out  1  timeout or misalignment flag; held until next accepted start
- mem_req  out  1  memory request
- mem_we  out  1  write enable, valid with mem_req
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_ready  in  1  memory accepts/completes the request in the same cycle
- mem_rdata  in  DATA_W  read word, valid when mem_req & mem_ready & ~mem_we

Behaviour:
- Reset (async): state IDLE. All outputs 0, including load_data, err, mem_* and the timeout counter.
- Reset mid-access drops `mem_req` immediately; no `done` is produced.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On `start`, register is_store, size, sign_ext, addr and store_data, clear `err` and `load_data`, and go to REQ.
  - `start` in any other state is ignored.
- REQ:
  - `mem_req` = 1; mem_we/mem_addr/mem_be/mem_wdata are driven from the registered request and held stable.
  - Timeout counter increments each REQ cycle.
  - If `mem_ready` = 1: a load registers the extracted `mem_rdata` into `load_data`; go to DONE.
  - Else if counter = TIMEOUT_CYC-1: `err` = 1, `load_data` = 0, go to DONE, and `mem_req` drops.
- DONE: `done` = 1 for exactly one cycle; `busy` = 0 in this cycle; go to IDLE.
- Latency: start at cycle N, first mem_req at N+1. If ready at N+1, done at N+2. Each wait state adds 1 cycle.
- `busy` = (state == REQ).
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Write data:
  - byte: {4{store_data[7:0]}}
  - half: {2{store_data[15:0]}}
  - word: store_data
- Load extract: mem_rdata >> (8 × byte offset), then keep 8/16/32 bits and sign- or zero-extend per `sign_ext`. The byte offset is addr[1:0] for byte and {addr[1],0} for half.
- Misalignment (half with addr[0]=1; word with addr[1:0]≠0) without the optional feature: the ignored low bits are dropped silently and the access proceeds aligned.

Optional Feature:
- Macro: MISALIGN_TRAP_EN
- Defined: a misaligned `start` goes IDLE→DONE directly with no `mem_req`. `err` = 1 and `load_data` = 0. Memory state is untouched.
- Undefined: truncation behaviour as above; `err` is set only by timeout.

Decomposition:
- Shared package `lsu_pkg`:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD
  - FSM state encoding
  - default TIMEOUT_CYC
- One combinational sub-module, `lsu_lane_align`: computes mem_be and mem_wdata, and extracts/extends load data from (size, sign_ext, addr[1:0]).
- FSM, registers and counter stay in the top.

Test Plan:
- Word load: addr=0x100, mem_ready high on first req cycle, rdata=0xDEADBEEF. Expect mem_addr=0x100, be=1111, done at start+2, load_data=0xDEADBEEF, err=0.
- Byte load with sign extension: addr=0x103, sign_ext=1, rdata=0x80FF_1234. Expect be=1000, load_data=0xFFFFFF80. With sign_ext=0, expect 0x00000080.
- Half store with 3 wait states: addr=0x22, store_data=0x0000ABCD. Expect be=1100, wdata=0xABCDABCD, mem_req held stable 4 cycles, done at start+5.
- Timeout: mem_ready never asserted, TIMEOUT_CYC=4. Expect mem_req high for exactly 4 cycles, then done, err=1, load_data=0. A second start clears err.
- Reset mid-REQ: assert reset asynchronously between clock edges while mem_req=1. Expect mem_req=0 and busy=0 immediately, no done, and a new start after reset completes normally.
- Misaligned word at addr=0x101:
  - MISALIGN_TRAP_EN defined: expect no mem_req, done at start+1, err=1.
  - Undefined: expect mem_addr=0x100, be=1111, err=0.
